// File: rtl/slicer_ref_ctrl.sv
// slicer_ref_ctrl: window-mean |x| threshold controller for the 4-ASK slicer (ports: clk, reset, clk_en, in_phs_sig, start/stop/freeze in; ref_level, ref_valid, win_done, state out)
module slicer_ref_ctrl #(
  parameter int                 LOG2_WIN    = 10,
  parameter logic signed [17:0] DEFAULT_REF = 18'sd32768,
  parameter logic signed [17:0] MIN_REF     = 18'sd256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic signed [17:0] in_phs_sig,
  input  logic               start,
  input  logic               stop,
  input  logic               freeze,
  output logic signed [17:0] ref_level,
  output logic               ref_valid,
  output logic               win_done,
  output logic [1:0]         state
);
  localparam int AW = LOG2_WIN + 17;
  typedef enum logic [1:0] {IDLE = 2'b00, ACQ = 2'b01, TRACK = 2'b10} state_t;
  state_t               st_q, st_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [LOG2_WIN-1:0]  cnt_q, cnt_d;
  logic signed [17:0]   ref_q, ref_d;
  logic                 val_q, val_d, done_q, done_d;
  logic [17:0]          neg, mean;
  logic [16:0]          x_abs;
  logic [AW-1:0]        sum;
  logic signed [17:0]   new_ref;
  // -131072 negates to itself (bit 17 still set), so it saturates to 131071
  assign neg     = -in_phs_sig;
  assign x_abs   = !in_phs_sig[17] ? in_phs_sig[16:0] : neg[17] ? 17'h1ffff : neg[16:0];
  assign sum     = acc_q + AW'(x_abs);
  assign mean    = 18'(sum >> LOG2_WIN);
  assign new_ref = ($signed(mean) < MIN_REF) ? MIN_REF : $signed(mean);
  always_comb begin
    st_d   = st_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ref_d  = ref_q;
    val_d  = val_q;
    done_d = 1'b0;
    if (clk_en) begin
      if (stop) begin
        st_d  = IDLE;
        acc_d = '0;
        cnt_d = '0;
      end else if (start) begin
        st_d  = ACQ;
        acc_d = '0;
        cnt_d = '0;
        val_d = 1'b0;
      end else if (st_q != IDLE) begin
        acc_d = (&cnt_q) ? '0 : sum;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          done_d = 1'b1;
          ref_d  = (st_q == ACQ || !freeze) ? new_ref : ref_q;
          val_d  = (st_q == ACQ) ? 1'b1 : val_q;
          st_d   = TRACK;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      acc_q  <= '0;
      cnt_q  <= '0;
      ref_q  <= DEFAULT_REF;
      val_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ref_q  <= ref_d;
      val_q  <= val_d;
      done_q <= done_d;
    end
  end
  assign ref_level = ref_q;
  assign ref_valid = val_q;
  assign win_done  = done_q;
  assign state     = st_q;
endmodule
